// File: rtl/usb_adc_stream.sv
// ADC sample capture into a word FIFO, streamed out as fixed-length USB bulk-IN packets.
// Samples are stored as 16-bit little-endian words and popped one byte at a time.
module usb_adc_stream #(
  parameter int ADC_W   = 10,
  parameter int DEPTH   = 512,
  parameter int PKT_LEN = 512,
  parameter int EP_NUM  = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ADC_W-1:0]         adc_dat_i,
  input  logic                     adc_val_i,
  input  logic                     enable_i,
  input  logic [7:0]               decim_i,
  input  logic                     flush_i,
  input  logic [3:0]               endpt_i,
  input  logic                     txact_i,
  input  logic                     txpop_i,
  output logic [7:0]               txdat_o,
  output logic [11:0]              txdat_len_o,
  output logic                     txcork_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t         state, state_nx;
  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [7:0]     decim_cnt;
  logic           phase;
  logic [10:0]    byte_cnt;

  logic ep_match, flush_ok, full, keep, wr_en, pop_ok, word_pop, last_pop;

  assign ep_match  = (endpt_i == 4'(EP_NUM));
  assign flush_ok  = flush_i && (state == ST_IDLE || state == ST_ARMED);
  assign full      = (level_o == LW'(DEPTH));
  assign keep      = enable_i && adc_val_i && (decim_cnt == 8'd0);
  assign wr_en     = keep && !flush_ok && !full;
  // Popping an empty FIFO would corrupt the pointers, so such pops are ignored.
  assign pop_ok    = (state == ST_SEND) && txpop_i && ep_match && (level_o != '0);
  assign word_pop  = pop_ok && phase;
  assign last_pop  = pop_ok && (byte_cnt == 11'(PKT_LEN - 1));

  assign txdat_len_o = 12'(PKT_LEN);
  assign txdat_o     = phase ? mem[rd_ptr][15:8] : mem[rd_ptr][7:0];

  // NOTE: sample storage has no reset; its contents are don't-care until written,
  // and leaving it unreset lets synthesis map it onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= 16'(adc_dat_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      phase      <= 1'b0;
      decim_cnt  <= 8'd0;
      overflow_o <= 1'b0;
      byte_cnt   <= 11'd0;
    end else begin
      state <= state_nx;

      if (!enable_i)      decim_cnt <= 8'd0;
      else if (adc_val_i) decim_cnt <= (decim_cnt >= decim_i) ? 8'd0 : decim_cnt + 8'd1;

      if (flush_ok) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_o <= '0;
        phase   <= 1'b0;
      end else begin
        if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
        if (word_pop) rd_ptr <= rd_ptr + 1'b1;
        if (pop_ok)   phase  <= ~phase;
        level_o <= level_o + LW'(wr_en) - LW'(word_pop);
      end

      if (!enable_i)                       overflow_o <= 1'b0;
      else if (keep && full && !flush_ok)  overflow_o <= 1'b1;

      if (state != ST_SEND) byte_cnt <= 11'd0;
      else if (pop_ok)      byte_cnt <= byte_cnt + 11'd1;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    txcork_o = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!flush_ok && level_o >= LW'(PKT_LEN / 2) && !txact_i) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        txcork_o = 1'b0;
        if (flush_ok)                 state_nx = ST_IDLE;
        else if (txact_i && ep_match) state_nx = ST_SEND;
      end
      ST_SEND: begin
        txcork_o = 1'b0;
        if (last_pop || !txact_i) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!txact_i) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_adc_stream.sv
// Directed bench for usb_adc_stream: packet streaming, decimation, overflow, aborts, reset, flush.
module tb_usb_adc_stream;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [9:0]  adc_dat;
  logic        adc_val, enable, flush, txact, txpop;
  logic [7:0]  decim;
  logic [3:0]  endpt;
  logic [7:0]  txdat;
  logic [11:0] txdat_len;
  logic        txcork, overflow;
  logic [4:0]  level;

  logic [9:0]  s_dat;
  logic        s_val, s_enable;
  logic [7:0]  s_txdat;
  logic [11:0] s_txdat_len;
  logic        s_txcork, s_overflow;
  logic [2:0]  s_level;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  usb_adc_stream #(.ADC_W(10), .DEPTH(16), .PKT_LEN(8), .EP_NUM(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .adc_dat_i(adc_dat), .adc_val_i(adc_val),
    .enable_i(enable), .decim_i(decim), .flush_i(flush), .endpt_i(endpt),
    .txact_i(txact), .txpop_i(txpop), .txdat_o(txdat), .txdat_len_o(txdat_len),
    .txcork_o(txcork), .overflow_o(overflow), .level_o(level)
  );

  usb_adc_stream #(.ADC_W(10), .DEPTH(4), .PKT_LEN(8), .EP_NUM(2)) dut_small (
    .clk_i(clk_i), .reset_i(reset_i), .adc_dat_i(s_dat), .adc_val_i(s_val),
    .enable_i(s_enable), .decim_i(8'd0), .flush_i(1'b0), .endpt_i(4'd0),
    .txact_i(1'b0), .txpop_i(1'b0), .txdat_o(s_txdat), .txdat_len_o(s_txdat_len),
    .txcork_o(s_txcork), .overflow_o(s_overflow), .level_o(s_level)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic [9:0] d);
    adc_dat = d;
    adc_val = 1'b1;
    tick();
    adc_val = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    tick();
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL reset_cork: got %b want 1", txcork); end
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", level); end
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vec_cnt++; if (txdat_len !== 12'd8) begin err_cnt++; $display("FAIL reset_len: got %0d want 8", txdat_len); end
  endtask

  task automatic test_packet();
    logic [7:0] exp [8];
    exp = '{8'hFF, 8'h03, 8'h01, 8'h00, 8'h55, 8'h01, 8'hAA, 8'h02};
    enable = 1'b1; decim = 8'd0; endpt = 4'd2;
    strobe(10'h3FF); strobe(10'h001); strobe(10'h155); strobe(10'h2AA);
    vec_cnt++; if (txcork !== 1'b0) begin err_cnt++; $display("FAIL pkt_armed_cork: got %b want 0", txcork); end
    vec_cnt++; if (level !== 5'd4) begin err_cnt++; $display("FAIL pkt_level: got %0d want 4", level); end
    txact = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (txdat !== exp[i]) begin err_cnt++; $display("FAIL pkt_byte%0d: got %h want %h", i, txdat, exp[i]); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL pkt_wait_cork: got %b want 1", txcork); end
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL pkt_level_end: got %0d want 0", level); end
    tick();
    vec_cnt++; if (txcork !== 1'b0 && txcork !== 1'b1) begin err_cnt++; $display("FAIL pkt_cork_x: got %b", txcork); end
    txact = 1'b0;
    tick();
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL pkt_idle_cork: got %b want 1", txcork); end
  endtask

  task automatic test_decim();
    logic [7:0] exp [8];
    exp = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h06, 8'h00, 8'h09, 8'h00};
    decim = 8'd2;
    for (int i = 0; i < 9; i++) strobe(10'(i));
    vec_cnt++; if (level !== 5'd3) begin err_cnt++; $display("FAIL decim_level: got %0d want 3", level); end
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL decim_cork: got %b want 1", txcork); end
    enable = 1'b0;
    tick();
    enable = 1'b1; decim = 8'd0;
    strobe(10'd9);
    vec_cnt++; if (txcork !== 1'b0) begin err_cnt++; $display("FAIL decim_armed: got %b want 0", txcork); end
    txact = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (txdat !== exp[i]) begin err_cnt++; $display("FAIL decim_byte%0d: got %h want %h", i, txdat, exp[i]); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL decim_level_end: got %0d want 0", level); end
    txact = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    s_enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_dat = 10'(i);
      s_val = 1'b1;
      tick();
      s_val = 1'b0;
      tick();
    end
    vec_cnt++; if (s_level !== 3'd4) begin err_cnt++; $display("FAIL ovf_level: got %0d want 4", s_level); end
    vec_cnt++; if (s_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag: got %b want 1", s_overflow); end
    vec_cnt++; if (s_txdat !== 8'h01) begin err_cnt++; $display("FAIL ovf_head: got %h want 01", s_txdat); end
    s_enable = 1'b0;
    tick();
    vec_cnt++; if (s_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear: got %b want 0", s_overflow); end
    vec_cnt++; if (s_level !== 3'd4) begin err_cnt++; $display("FAIL ovf_level_keep: got %0d want 4", s_level); end
  endtask

  task automatic test_wrong_ep_abort();
    logic [7:0] exp1 [3];
    logic [7:0] exp2 [3];
    exp1 = '{8'h11, 8'h01, 8'h22};
    exp2 = '{8'h02, 8'h33, 8'h03};
    strobe(10'h111); strobe(10'h222); strobe(10'h333); strobe(10'h344);
    endpt = 4'd1; txact = 1'b1;
    tick();
    txpop = 1'b1;
    repeat (2) tick();
    txpop = 1'b0;
    tick();
    vec_cnt++; if (txcork !== 1'b0) begin err_cnt++; $display("FAIL ep_cork: got %b want 0", txcork); end
    vec_cnt++; if (level !== 5'd4) begin err_cnt++; $display("FAIL ep_level: got %0d want 4", level); end
    vec_cnt++; if (txdat !== 8'h11) begin err_cnt++; $display("FAIL ep_head: got %h want 11", txdat); end
    txact = 1'b0; endpt = 4'd2;
    tick();
    txact = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (txdat !== exp1[i]) begin err_cnt++; $display("FAIL abort_byte%0d: got %h want %h", i, txdat, exp1[i]); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    txact = 1'b0;
    tick();
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL abort_cork: got %b want 1", txcork); end
    vec_cnt++; if (level !== 5'd3) begin err_cnt++; $display("FAIL abort_level: got %0d want 3", level); end
    tick();
    strobe(10'h355);
    vec_cnt++; if (txcork !== 1'b0) begin err_cnt++; $display("FAIL rearm_cork: got %b want 0", txcork); end
    txact = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (txdat !== exp2[i]) begin err_cnt++; $display("FAIL resume_byte%0d: got %h want %h", i, txdat, exp2[i]); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    txact = 1'b0;
    repeat (2) tick();
    vec_cnt++; if (level !== 5'd2) begin err_cnt++; $display("FAIL resume_level: got %0d want 2", level); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL idle_flush_level: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] exp [5];
    exp = '{8'hA1, 8'h00, 8'hB2, 8'h00, 8'hC3};
    strobe(10'h0A1); strobe(10'h0B2); strobe(10'h0C3); strobe(10'h0D4);
    txact = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (txdat !== exp[i]) begin err_cnt++; $display("FAIL rst_byte%0d: got %h want %h", i, txdat, exp[i]); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL rst_cork: got %b want 1", txcork); end
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL rst_level: got %0d want 0", level); end
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    txact = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [7:0] exp [6];
    exp = '{8'hE1, 8'h02, 8'hD2, 8'h03, 8'hC3, 8'h00};
    strobe(10'h1F0); strobe(10'h2E1); strobe(10'h3D2); strobe(10'h0C3);
    vec_cnt++; if (level !== 5'd4) begin err_cnt++; $display("FAIL flush_pre_level: got %0d want 4", level); end
    vec_cnt++; if (txdat !== 8'hF0) begin err_cnt++; $display("FAIL flush_phase0: got %h want F0", txdat); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL flush_level: got %0d want 0", level); end
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL flush_cork: got %b want 1", txcork); end
    tick();
    strobe(10'h1F0); strobe(10'h2E1); strobe(10'h3D2); strobe(10'h0C3);
    txact = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (txdat !== (i == 0 ? 8'hF0 : 8'h01)) begin err_cnt++; $display("FAIL send_byte%0d: got %h", i, txdat); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vec_cnt++; if (level !== 5'd3) begin err_cnt++; $display("FAIL send_flush_level: got %0d want 3", level); end
    vec_cnt++; if (txcork !== 1'b0) begin err_cnt++; $display("FAIL send_flush_cork: got %b want 0", txcork); end
    for (int i = 0; i < 6; i++) begin
      vec_cnt++;
      if (txdat !== exp[i]) begin err_cnt++; $display("FAIL send_tail%0d: got %h want %h", i, txdat, exp[i]); end
      txpop = 1'b1;
      tick();
    end
    txpop = 1'b0;
    vec_cnt++; if (txcork !== 1'b1) begin err_cnt++; $display("FAIL send_end_cork: got %b want 1", txcork); end
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL send_end_level: got %0d want 0", level); end
    txact = 1'b0;
    tick();
  endtask

  initial begin
    reset_i = 1'b0; adc_dat = '0; adc_val = 1'b0; enable = 1'b0; decim = 8'd0;
    flush = 1'b0; endpt = 4'd0; txact = 1'b0; txpop = 1'b0;
    s_dat = '0; s_val = 1'b0; s_enable = 1'b0;
    test_reset();
    test_packet();
    test_decim();
    test_overflow();
    test_wrong_ep_abort();
    test_reset_mid_packet();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_adc_stream.md
USB_ADC_STREAM -- requirements
Module: usb_adc_stream

Interface
REQ-001 SHALL have parameter ADC_W, default 10, ADC sample width (1..16).
REQ-002 SHALL have parameter DEPTH, default 512, FIFO depth in 16-bit words (power of two, >= PKT_LEN/2).
REQ-003 SHALL have parameter PKT_LEN, default 512, bulk-IN packet length in bytes (even, <= 1024).
REQ-004 SHALL have parameter EP_NUM, default 2, USB IN endpoint number served.
REQ-005 SHALL have one clock and one reset: clk_i  in  1  sole clock (USB controller clock); reset_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have these ports:
- adc_dat_i  in  ADC_W  sample data
- adc_val_i  in  1  one-cycle sample strobe
- enable_i  in  1  capture enable
- decim_i  in  8  keep 1 of (decim_i+1) strobes
- flush_i  in  1  clear FIFO
- endpt_i  in  4  endpoint selected by controller
- txact_i  in  1  controller IN transaction active
- txpop_i  in  1  controller consumes one byte
- txdat_o  out  8  byte at FIFO head
- txdat_len_o  out  12  packet length
- txcork_o  out  1  high = no packet ready (NAK)
- overflow_o  out  1  sticky sample-drop flag
- level_o  out  $clog2(DEPTH)+1  FIFO word count

Function
REQ-007 SHALL zero-extend each stored sample to 16 bits and store it as one FIFO word.
REQ-008 SHALL count strobes only while enable_i=1; decimation counter runs 0..decim_i and wraps; a sample is stored when the counter is 0; decim_i=0 stores every strobe.
REQ-009 SHALL clear the decimation counter to 0 while enable_i=0.
REQ-010 SHALL drop a kept sample when level_o==DEPTH at that cycle (even if a word pops the same cycle) and set overflow_o; overflow_o clears only when enable_i=0 or on reset.
REQ-011 SHALL drive txdat_len_o constant PKT_LEN.
REQ-012 SHALL run state machine IDLE, ARMED, SEND, WAIT.
REQ-013 IDLE: txcork_o=1; -> ARMED when level_o >= PKT_LEN/2 and txact_i=0.
REQ-014 ARMED: txcork_o=0; -> SEND when txact_i=1 and endpt_i==EP_NUM.
REQ-015 SEND: txcork_o=0; each txpop_i advances byte phase; -> WAIT after the PKT_LEN-th pop, or on txact_i falling early.
REQ-016 WAIT: txcork_o=1; -> IDLE when txact_i=0.
REQ-017 SHALL ignore txpop_i outside SEND and when endpt_i!=EP_NUM.
REQ-018 txdat_o SHALL be combinational from the FIFO head: low byte when phase=0, high byte when phase=1; little-endian per sample.
REQ-019 A pop at phase 0 SHALL set phase=1; a pop at phase 1 SHALL remove the head word and set phase=0.
REQ-020 Pops are destructive; an aborted packet SHALL NOT be rewound; phase SHALL be kept across packets.
REQ-021 Pointers SHALL wrap modulo DEPTH; level_o SHALL reflect a same-cycle write and word-pop as net zero.
REQ-022 flush_i SHALL be honoured only in IDLE or ARMED: pointers, level_o and phase clear next cycle, state -> IDLE; in SEND/WAIT it SHALL be ignored.
REQ-023 Simultaneous flush_i and kept sample in IDLE/ARMED: flush wins, sample dropped without setting overflow_o.

Reset
REQ-024 On reset_i=1 (asynchronous, any cycle incl. mid-packet): state IDLE, pointers/level_o/phase/decimation counter 0, overflow_o=0, txcork_o=1.
REQ-025 txdat_o SHALL be don't-care while level_o=0; txdat_len_o=PKT_LEN at all times.

Verification
REQ-026 ADC_W=10, PKT_LEN=8, decim_i=0, 4 strobes 0x3FF,0x001,0x155,0x2AA -> txcork_o falls; endpt 2 transaction, 8 pops yield FF 03 01 00 55 01 AA 02, then WAIT, cork=1.
REQ-027 decim_i=2, 9 strobes 0..8 -> only 0,3,6 stored, level_o=3.
REQ-028 DEPTH=4, 6 kept strobes, no reads -> level_o=4, overflow_o=1, samples 5-6 lost; enable_i=0 -> overflow_o=0.
REQ-029 Packet with endpt_i=1 -> no state change, no pops; txact_i falls after 3 pops at endpt 2 -> WAIT, phase=1, next packet starts with the high byte of word 2.
REQ-030 reset_i pulse in SEND after 5 pops -> next cycle txcork_o=1, level_o=0, overflow_o=0.
REQ-031 flush_i in ARMED with level_o=4 -> level_o=0, IDLE; flush_i in SEND -> ignored.
